traffic_light_controller: RTL and testbench

- Fixed-time traffic-light sequencer for a T-junction with four signal heads: main road direction 1 (M1), main road direction 2 (M2), main-road turn (MT) and side road (S).
- Moore FSM with a shared dwell counter. It cycles through six phases with parameterised durations counted in clock cycles.
- Free-running top-level block with no inputs other than clock and reset. It drives the lamp outputs directly.

---
 rtl/traffic_light_controller.sv | 109 ++++++++++
 tb/tb_traffic_light_controller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// Fixed-time six-phase sequencer for a T-junction (M1, M2, main turn, side road).
// Moore FSM sharing one dwell counter; lamps are a pure decode of the phase.
module traffic_light_controller #(
    parameter int unsigned T_MAIN = 7,
    parameter int unsigned T_YEL  = 2,
    parameter int unsigned T_TURN = 5,
    parameter int unsigned T_SIDE = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] light_M1,
    output logic [2:0] light_S,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [CNT_W-1:0] LAST_MAIN = CNT_W'(T_MAIN - 32'd1);
    localparam logic [CNT_W-1:0] LAST_YEL  = CNT_W'(T_YEL  - 32'd1);
    localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(T_TURN - 32'd1);
    localparam logic [CNT_W-1:0] LAST_SIDE = CNT_W'(T_SIDE - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        P1 = 3'd0,
        P2 = 3'd1,
        P3 = 3'd2,
        P4 = 3'd3,
        P5 = 3'd4,
        P6 = 3'd5
    } phase_e;

    phase_e           state_q, state_d, nxt_s;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_s;
    logic             valid_s;

    // Phase and dwell counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= P1;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next phase, dwell limit and counter update.
    always_comb begin
        nxt_s   = P1;
        last_s  = LAST_MAIN;
        valid_s = 1'b1;
        state_d = P1;
        cnt_d   = CNT_ZERO;
        case (state_q)
            P1: begin last_s = LAST_MAIN; nxt_s = P2; end
            P2: begin last_s = LAST_YEL;  nxt_s = P3; end
            P3: begin last_s = LAST_TURN; nxt_s = P4; end
            P4: begin last_s = LAST_YEL;  nxt_s = P5; end
            P5: begin last_s = LAST_SIDE; nxt_s = P6; end
            P6: begin last_s = LAST_YEL;  nxt_s = P1; end
            default: begin
                last_s  = LAST_MAIN;
                nxt_s   = P1;
                valid_s = 1'b0;
            end
        endcase

        // An illegal encoding falls back to P1 with a fresh dwell.
        if (!valid_s) begin
            state_d = P1;
            cnt_d   = CNT_ZERO;
        end else if (cnt_q == last_s) begin
            state_d = nxt_s;
            cnt_d   = CNT_ZERO;
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    // Lamp decode; anything unrecognised shows all red.
    always_comb begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
        case (state_q)
            P1: begin light_M1 = GRN; light_M2 = GRN; end
            P2: begin light_M1 = GRN; light_M2 = YEL; end
            P3: begin light_M1 = GRN; light_MT = GRN; end
            P4: begin light_M1 = YEL; light_MT = YEL; end
            P5: begin light_S  = GRN; end
            P6: begin light_S  = YEL; end
            default: begin
                light_M1 = RED;
                light_M2 = RED;
                light_MT = RED;
                light_S  = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: default and all-ones timing instances against
// a cycle-position reference model, with random asynchronous reset pulses.
module tb_traffic_light_controller;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] d_m1, d_s, d_m2, d_mt;
    logic [2:0] o_m1, o_s, o_m2, o_mt;
    int         n_def, n_ovr;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    traffic_light_controller dut_def (
        .clk(clk), .rst(rst),
        .light_M1(d_m1), .light_S(d_s), .light_M2(d_m2), .light_MT(d_mt)
    );

    traffic_light_controller #(
        .T_MAIN(1), .T_YEL(1), .T_TURN(1), .T_SIDE(1)
    ) dut_ovr (
        .clk(clk), .rst(rst),
        .light_M1(o_m1), .light_S(o_s), .light_M2(o_m2), .light_MT(o_mt)
    );

    // Expected {M1,M2,MT,S} at cycle n after reset release, from the phase table.
    function automatic logic [11:0] exp_lamps(input int n, input int tm, input int ty,
                                              input int tt, input int ts);
        int p;
        p = n % (tm + tt + ts + 3 * ty);
        if (p < tm) return {GRN, GRN, RED, RED};
        p = p - tm;
        if (p < ty) return {GRN, YEL, RED, RED};
        p = p - ty;
        if (p < tt) return {GRN, RED, GRN, RED};
        p = p - tt;
        if (p < ty) return {YEL, RED, YEL, RED};
        p = p - ty;
        if (p < ts) return {RED, RED, RED, GRN};
        return {RED, RED, RED, YEL};
    endfunction

    function automatic logic inv_ok(input logic [2:0] m1, input logic [2:0] m2,
                                    input logic [2:0] mt, input logic [2:0] s);
        logic ok;
        ok = $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s);
        if (s != RED && !(m1 == RED && m2 == RED && mt == RED)) ok = 1'b0;
        if (mt != RED && m2 != RED) ok = 1'b0;
        if (m2 == GRN && mt != RED) ok = 1'b0;
        return ok;
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic check_all();
        check_eq("def_lamps", {d_m1, d_m2, d_mt, d_s}, exp_lamps(n_def, 7, 2, 5, 3));
        check_eq("def_invariant", {11'd0, inv_ok(d_m1, d_m2, d_mt, d_s)}, 12'd1);
        check_eq("ovr_lamps", {o_m1, o_m2, o_mt, o_s}, exp_lamps(n_ovr, 1, 1, 1, 1));
        check_eq("ovr_invariant", {11'd0, inv_ok(o_m1, o_m2, o_mt, o_s)}, 12'd1);
    endtask

    task automatic step();
        @(posedge clk);
        n_def++;
        n_ovr++;
        @(negedge clk);
        check_all();
    endtask

    // Raise reset between edges, check the immediate snap to P1, hold, release between edges.
    task automatic pulse_reset(input int hold);
        #2 rst = 1'b1;
        #1;
        n_def = 0;
        n_ovr = 0;
        check_all();
        repeat (hold) begin
            @(negedge clk);
            check_all();
        end
        #2 rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        n_def = 0;
        n_ovr = 0;
        #1;
        check_all();
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        #2 rst = 1'b0;

        // Run into P3 (n=11) and abort it with a reset pulse.
        repeat (11) step();
        pulse_reset(1);

        for (int i = 0; i < 600; i++) begin
            step();
            if ($urandom_range(0, 59) == 0) pulse_reset(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
